// File: rtl/wgt_dbuf.sv
// Double-buffered kernel weight store: columns stream into the shadow bank
// while the active bank drives wgt_out; a handshake swaps the two banks.
module wgt_dbuf #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 3,
  parameter int IN_WIDTH   = 32,
  parameter int NUM_CH     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_WIDTH-1:0]                in_data,
  input  logic                               flush,
  input  logic                               swap_req,
  output logic                               swap_ack,
  output logic                               out_valid,
  output logic [NUM_CH*K*K*DATA_WIDTH-1:0]   wgt_out
);

  localparam int NW = NUM_CH * K * K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int HW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  generate
    if (IN_WIDTH < K * DATA_WIDTH) begin : g_width_chk
      $error("wgt_dbuf: IN_WIDTH must be at least K*DATA_WIDTH");
    end
    if (IN_WIDTH > K * DATA_WIDTH) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^in_data[IN_WIDTH-1:K*DATA_WIDTH];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] bank_a [NW];
  logic [DATA_WIDTH-1:0] bank_b [NW];
  logic                  act;  // 0: bank A active, B is shadow
  logic                  shadow_full;
  logic [CW-1:0]         col_cnt;
  logic [HW-1:0]         ch_cnt;
  logic                  beat;
  logic                  swap;

  assign in_ready = !shadow_full && !flush;
  assign beat     = in_valid && in_ready;
  assign swap     = swap_req && shadow_full && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act         <= 1'b0;
      shadow_full <= 1'b0;
      col_cnt     <= '0;
      ch_cnt      <= '0;
      out_valid   <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      swap_ack <= swap;
      if (flush) begin
        shadow_full <= 1'b0;
        col_cnt     <= '0;
        ch_cnt      <= '0;
      end else begin
        if (swap) begin
          act         <= ~act;
          shadow_full <= 1'b0;
          out_valid   <= 1'b1;
        end
        // beat and swap are mutually exclusive: beat needs an empty-ish shadow
        if (beat) begin
          if (col_cnt == CW'(K - 1)) begin
            col_cnt <= '0;
            if (ch_cnt == HW'(NUM_CH - 1)) begin
              ch_cnt      <= '0;
              shadow_full <= 1'b1;
            end else begin
              ch_cnt <= ch_cnt + HW'(1);
            end
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
      end
    end
  end

  // Element i = n*K*K + r*K + c; a beat fills column c of kernel n, rows 0..K-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (beat) begin
      for (int i = 0; i < NW; i++) begin
        if ((i / (K * K)) == int'(ch_cnt) && (i % K) == int'(col_cnt)) begin
          if (act)
            bank_a[i] <= in_data[(K - (i % (K * K)) / K) * DATA_WIDTH - 1 -: DATA_WIDTH];
          else
            bank_b[i] <= in_data[(K - (i % (K * K)) / K) * DATA_WIDTH - 1 -: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    wgt_out = '0;
    for (int i = 0; i < NW; i++) begin
      wgt_out[i*DATA_WIDTH +: DATA_WIDTH] = act ? bank_b[i] : bank_a[i];
    end
  end

endmodule

// File: tb/tb_wgt_dbuf.sv
// Randomized bench for wgt_dbuf against a beat-queue reference model.
module tb_wgt_dbuf;
  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int IW   = 32;
  localparam int NCH  = 4;
  localparam int NW   = NCH * K * K;
  localparam int FILL = K * NCH;

  logic clk = 0;
  logic rst, in_valid, in_ready, flush, swap_req, swap_ack, out_valid;
  logic [IW-1:0] in_data;
  logic [NW*DW-1:0] wgt_out;

  wgt_dbuf #(.DATA_WIDTH(DW), .K(K), .IN_WIDTH(IW), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .swap_req(swap_req),
    .swap_ack(swap_ack), .out_valid(out_valid), .wgt_out(wgt_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: shadow bank is just the list of accepted beats.
  logic [IW-1:0] q[$];
  int exp_w [NW];
  bit exp_valid, exp_ack;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int elem(input int i);
    logic signed [DW-1:0] v;
    v = wgt_out[i*DW +: DW];
    return int'(v);
  endfunction

  function automatic int sx(input int v);
    return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (exp_w[i]) exp_w[i] = 0;
    exp_valid = 0;
    exp_ack   = 0;
  endtask

  task automatic model_edge();
    exp_ack = 0;
    if (flush) begin
      q.delete();
    end else if (swap_req && q.size() == FILL) begin
      for (int j = 0; j < FILL; j++)
        for (int r = 0; r < K; r++)
          exp_w[(j / K) * K * K + r * K + (j % K)] =
            sx(int'((q[j] >> ((K - 1 - r) * DW)) & ((1 << DW) - 1)));
      q.delete();
      exp_valid = 1;
      exp_ack   = 1;
    end else if (in_valid && q.size() < FILL) begin
      q.push_back(in_data);
    end
  endtask

  // Called at posedge+1 with inputs already set for the coming edge.
  task automatic step();
    #1;
    chk("in_ready", in_ready, (q.size() < FILL) && !flush);
    @(posedge clk);
    model_edge();
    #1;
    chk("swap_ack", swap_ack, exp_ack);
    chk("out_valid", out_valid, exp_valid);
    for (int i = 0; i < NW; i++) chk($sformatf("wgt%0d", i), elem(i), exp_w[i]);
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_wgt", |wgt_out, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic beat(input logic [IW-1:0] w);
    in_valid = 1;
    in_data  = w;
    step();
    in_valid = 0;
  endtask

  task automatic load(input int n);
    for (int j = 0; j < n; j++) beat($urandom);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; flush = 0; swap_req = 0;
    model_reset();
    #7;
    // basic load with swap_req held from reset
    swap_req = 1;
    do_reset();
    beat(32'h00_01_02_03);
    load(FILL - 1);
    step();
    chk("k0e0", elem(0), 1);
    chk("k0e3", elem(3), 2);
    chk("k0e6", elem(6), 3);
    step();
    swap_req = 0;

    // ping-pong: second set loads while first stays visible
    beat(32'h00_80_7f_81);
    load(FILL - 1);
    step();
    swap_req = 1;
    step();
    swap_req = 0;
    chk("neg128", elem(0), -128);
    chk("pos127", elem(3), 127);
    chk("neg127", elem(6), -127);
    step();

    // flush mid-fill, with swap_req and in_valid colliding with flush
    load(5);
    flush = 1; swap_req = 1; in_valid = 1; in_data = $urandom;
    step();
    flush = 0; swap_req = 0; in_valid = 0;
    load(FILL);
    swap_req = 1;
    step();
    swap_req = 0;

    // backpressure with full shadow
    load(FILL);
    for (int j = 0; j < 4; j++) begin
      in_valid = 1; in_data = $urandom;
      step();
    end
    in_valid = 0;
    flush = 1; swap_req = 1;
    step();
    flush = 0;
    for (int j = 0; j < 3; j++) step();
    swap_req = 0;

    // reset mid-fill
    load(7);
    #3;
    do_reset();
    step();
    load(FILL - 1);
    swap_req = 1;
    step();
    beat($urandom);
    swap_req = 1;
    step();
    step();
    swap_req = 0;

    // random traffic
    for (int t = 0; t < 400; t++) begin
      in_valid = ($urandom % 4) != 0;
      in_data  = $urandom;
      flush    = ($urandom % 40) == 0;
      swap_req = ($urandom % 3) == 0;
      step();
    end
    in_valid = 0; flush = 0; swap_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wgt_dbuf.md
WGT_DBUF -- requirements
Module: wgt_dbuf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning signed weight element width.
REQ-002 SHALL have parameter K, default 3, meaning kernel side; each kernel holds K*K weights.
REQ-003 SHALL have parameter IN_WIDTH, default 32, meaning input word width; IN_WIDTH < K*DATA_WIDTH is an elaboration error.
REQ-004 SHALL have parameter NUM_CH, default 4, meaning kernels held per bank.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  meaning in_data carries one kernel column.
REQ-008 SHALL have port in_ready  output  1  meaning the block accepts a beat this cycle.
REQ-009 SHALL have port in_data  input  IN_WIDTH  meaning packed column, signed elements.
REQ-010 SHALL have port flush  input  1  meaning discard the partially or fully loaded shadow bank.
REQ-011 SHALL have port swap_req  input  1  meaning the consumer requests the next weight set; level, held until swap_ack.
REQ-012 SHALL have port swap_ack  output  1  meaning one-cycle pulse, swap performed.
REQ-013 SHALL have port out_valid  output  1  meaning the active bank holds a complete set.
REQ-014 SHALL have port wgt_out  output  NUM_CH*K*K*DATA_WIDTH  meaning active-bank weights; kernel n, element r*K+c at slice index (n*K*K + r*K + c).

Function
REQ-015 SHALL contain two banks (A, B) of NUM_CH*K*K registers; one is active (drives wgt_out), the other is shadow (loaded).
REQ-016 SHALL accept a beat when in_valid && in_ready at the rising clk edge.
REQ-017 SHALL compute in_ready = !shadow_full && !flush (combinational).
REQ-018 SHALL write accepted beat to shadow kernel ch_cnt, column col_cnt: row r taken from in_data[(K-r)*DATA_WIDTH-1 : (K-r-1)*DATA_WIDTH]; bits above K*DATA_WIDTH ignored.
REQ-019 SHALL advance col_cnt 0..K-1 per accepted beat, wrapping to 0 and incrementing ch_cnt 0..NUM_CH-1.
REQ-020 SHALL, on the accepted beat with col_cnt=K-1 and ch_cnt=NUM_CH-1, set shadow_full=1 and wrap both counters to 0; fill = K*NUM_CH beats.
REQ-021 SHALL hold all bank registers unchanged on cycles with no accepted beat and no reset.
REQ-022 SHALL perform a swap on the rising edge where swap_req && shadow_full && !flush: toggle active pointer, clear shadow_full, set out_valid=1, assert swap_ack for exactly the following cycle.
REQ-023 SHALL ignore swap_req while shadow_full=0 (no ack, no state change, nothing latched).
REQ-024 SHALL not swap in the same edge as the final beat; earliest swap is the next edge (shadow_full is registered).
REQ-025 SHALL present new-bank weights on wgt_out from the cycle following the swap edge (registered bank select, no combinational path from swap_req).
REQ-026 SHALL, on flush=1, reset col_cnt, ch_cnt, shadow_full to 0 and suppress swap; active bank, active pointer, out_valid unchanged; flush has priority over beat and swap in the same cycle.
REQ-027 SHALL keep out_valid=1 once set until reset.
REQ-028 SHALL allow loading of the new shadow bank to begin the cycle after swap (in_ready reasserts).

Reset
REQ-029 SHALL, on rst=1 (any time, asynchronous), clear all bank registers to 0, counters to 0, shadow_full=0, active pointer=A, out_valid=0, swap_ack=0; a partial fill in progress is lost.
REQ-030 SHALL hold in_ready=1 immediately after reset release (flush=0).

Verification
REQ-031 SHALL verify basic load (defaults): 12 beats, beat0 = 0x00_01_02_03 -> after swap, kernel0 elements 0,3,6 = 1,2,3; shadow_full after beat 12, in_ready=0.
REQ-032 SHALL verify swap timing: swap_req held from reset -> swap_ack single pulse 1 cycle after shadow_full edge; out_valid=1; wgt_out updated same cycle as swap_ack.
REQ-033 SHALL verify ping-pong: load set X, swap, load set Y while wgt_out stays X, swap -> wgt_out = Y; values 0x80 read as -128.
REQ-034 SHALL verify flush mid-fill: 5 beats, flush, 12 new beats, swap -> wgt_out contains only new beats; active bank untouched during flush.
REQ-035 SHALL verify backpressure and boundaries: in_valid held with shadow full -> no beats accepted, counters stable; swap_req with empty shadow -> no ack; flush and swap_req same cycle -> no swap.
REQ-036 SHALL verify reset mid-fill: rst pulse after 7 beats -> all outputs 0, out_valid=0, next fill requires full 12 beats.
